dmem_ctlr: RTL and testbench
============================

// Module: dmem_ctlr
// PURPOSE
//  Memory-side responder for the dcache miss path. Accepts BUS_LOAD/BUS_STORE commands
//  issued from the dcache MSHR queue and grants a nonzero 4-bit response tag in the same cycle.
//  Stores are committed to a 64-bit-line backing store.
//  Load data is returned later with its tag on the Ctlr2proc_* return bus.
//  Sits between the dcache and the shared memory model. Used standalone as the dcache bench partner.
// PARAMETERS
//  LATENCY    4    cycles from load acceptance to data return; legal range 1..14
//  MEM_LINES  256  number of 64-bit lines in the backing store; power of 2
//  `XLEN      32   address width (global macro)
// PORTS
//  clock                input   1      clock
//  reset                input   1      reset, synchronous, active-high
//  dcache2ctlr_command  input   2      BUS_NONE=2'd0, BUS_LOAD=2'd1, BUS_STORE=2'd2, 2'd3 treated as NONE
//  dcache2ctlr_addr     input   XLEN   line address; bits [2:0] ignored
//  dcache2ctlr_data     input   64     store line data
//  Ctlr2proc_response   output  4      combinational; nonzero = command accepted this cycle with that tag
//  Ctlr2proc_data       output  64     registered; load line data, valid when Ctlr2proc_tag!=0
//  Ctlr2proc_tag        output  4      registered; tag of returning load, 0 = no return
// BEHAVIOUR
//  - Tag pool: tags 1..15, one busy bit each. Tag 0 is never granted.
//    free_tag = lowest-numbered non-busy tag; none free => pool full.
//  - Accept condition: command is LOAD or STORE, pool not full, and (if enabled) no injected stall.
//    On accept, Ctlr2proc_response=free_tag. Otherwise response=0 and nothing changes.
//  - At most one accept per cycle. The dcache holds command/addr/data until it sees a nonzero response.
//  - Line index = addr[3 +: log2(MEM_LINES)]; address bits above the index are ignored (aliasing).
//  - STORE accepted in cycle T: mem[idx] <= data at the end of T. The granted tag is NOT marked busy.
//    No return is ever generated for a store.
//  - LOAD accepted in cycle T: at the end of T, the pending entry for that tag captures mem[idx].
//    Busy is set and the counter is loaded with LATENCY.
//    mem[idx] here is the value BEFORE any same-cycle write; none is possible, one accept/cycle.
//    Consequences: a store accepted before a load is visible to it; a store accepted after is not.
//  - Each cycle every busy counter decrements. The entry whose counter reaches 0 drives the return:
//    Ctlr2proc_tag=tag and Ctlr2proc_data=captured line during cycle T+LATENCY, for exactly 1 cycle.
//    Otherwise tag=0 and data=64'h0.
//  - Fixed latency plus one accept/cycle => at most one entry expires per cycle; no return arbitration.
//  - Busy bit clears at the end of the return cycle; the tag is grantable again from T+LATENCY+1.
//  - Full: 15 loads outstanding => response 0 for both LOAD and STORE until a tag frees.
//  - Stall-free throughput is 1 load/cycle. With LATENCY<=14, 15 tags never fill.
//  - Reset (any cycle, incl. mid-transfer): all busy bits and counters cleared and memory cleared to 0.
//    Ctlr2proc_tag=0, Ctlr2proc_data=0 the cycle after reset is sampled.
//    Ctlr2proc_response=0 while reset is high. In-flight loads are dropped with no return.
//  - Read-modify-write merging of partial stores is the dcache's job; here stores write the full line.
// CONFIGURATION
//  DMEM_STALL_INJECT_EN defined:
//    - 8-bit Fibonacci LFSR, taps 8,6,5,4, reset seed 8'hA5, advances every cycle.
//    - When lfsr[1:0]==2'b00, acceptance is refused (response=0) regardless of pool state.
//    - Used to exercise the dcache issue-retry path.
//  DMEM_STALL_INJECT_EN undefined:
//    - No LFSR is present; acceptance depends only on command and pool state.
// TESTING
//  - Reset, then LOAD addr 32'h40 at T -> response 4'd1 at T.
//    tag=1, data=64'h0 at T+4; tag=0 at T+3 and T+5.
//  - STORE addr 32'h48 data 64'hDEAD_BEEF_0123_4567 at T, LOAD 32'h48 at T+1.
//    Response 1 at T, 1 at T+1 (store does not hold a tag); return tag=1 with 64'hDEAD_BEEF_0123_4567 at T+5.
//  - LOAD 32'h80 at T, STORE 32'h80 data 64'h1 at T+1 -> load returns old value 64'h0 at T+4.
//  - 15 back-to-back LOADs with LATENCY=14 from T -> responses 1..15 at T..T+14.
//    No full stall; tag 1 returns at T+14 and is re-granted at T+15.
//  - LOAD at T, reset asserted at T+2 for 1 cycle -> no nonzero Ctlr2proc_tag through T+10.
//    The next LOAD gets tag 1.
//  - With DMEM_STALL_INJECT_EN: hold LOAD for 64 cycles.
//    response==0 exactly on cycles with lfsr[1:0]==0; every grant returns after LATENCY.

Source files
------------

// File: rtl/dmem_ctlr.sv
// dmem_ctlr: memory-side responder for the dcache miss path.
//
// Accepts BUS_LOAD / BUS_STORE commands and grants a nonzero 4-bit tag in the same cycle.
// Stores write a full 64-bit line into the backing store. Loads capture the addressed line at
// acceptance and return it with its tag LATENCY cycles later.
//
// Parameters:
//   LATENCY    cycles from load acceptance to data return (1..14)
//   MEM_LINES  number of 64-bit lines in the backing store (power of 2)
//
// Ports:
//   clock                in   clock
//   reset                in   synchronous, active-high reset
//   dcache2ctlr_command  in   0 = none, 1 = load, 2 = store, 3 = none
//   dcache2ctlr_addr     in   line address; bits [2:0] ignored
//   dcache2ctlr_data     in   store line data
//   Ctlr2proc_response   out  combinational; nonzero = accepted this cycle with that tag
//   Ctlr2proc_data       out  registered load return data (zero when no return)
//   Ctlr2proc_tag        out  registered load return tag (zero when no return)
//
// Optional build macro DMEM_STALL_INJECT_EN adds an 8-bit LFSR that randomly refuses
// acceptance, used to exercise the dcache retry path.

`ifndef XLEN
`define XLEN 32
`endif

module dmem_ctlr #(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned MEM_LINES = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        dcache2ctlr_command,
  input  logic [`XLEN-1:0]  dcache2ctlr_addr,
  input  logic [63:0]       dcache2ctlr_data,
  output logic [3:0]        Ctlr2proc_response,
  output logic [63:0]       Ctlr2proc_data,
  output logic [3:0]        Ctlr2proc_tag
);

  localparam int unsigned IdxW = $clog2(MEM_LINES);
  // Counter holds cycles remaining until the return cycle, so it is 0 during the return
  // cycle itself; loading LATENCY-1 gives a return exactly LATENCY cycles after accept.
  localparam logic [3:0] CntInit = 4'(LATENCY - 1);

  localparam logic [1:0] BusLoad  = 2'd1;
  localparam logic [1:0] BusStore = 2'd2;

  logic [63:0]     mem_q  [MEM_LINES];
  logic [15:1]     busy_q;
  logic [3:0]      cnt_q  [1:15];
  logic [63:0]     line_q [1:15];

  logic [3:0]      free_tag;
  logic            pool_full;
  logic            stall;
  logic            is_load;
  logic            is_store;
  logic            accept;
  logic [IdxW-1:0] idx;
  logic [63:0]     rd_line;
  logic [3:0]      ret_tag_d;
  logic [63:0]     ret_data_d;

  logic            unused_addr;
  assign unused_addr = ^{dcache2ctlr_addr[2:0], dcache2ctlr_addr[`XLEN-1:3+IdxW]};

`ifdef DMEM_STALL_INJECT_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR, taps 8,6,5,4.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Lowest-numbered free tag; scanning downward lets the lowest win.
  always_comb begin
    free_tag = 4'd0;
    for (int t = 15; t >= 1; t--) begin
      if (!busy_q[t]) free_tag = 4'(t);
    end
  end

  assign pool_full = &busy_q;
  assign is_load   = (dcache2ctlr_command == BusLoad);
  assign is_store  = (dcache2ctlr_command == BusStore);
  assign accept    = (is_load || is_store) && !pool_full && !stall && !reset;

  assign Ctlr2proc_response = accept ? free_tag : 4'd0;

  assign idx     = dcache2ctlr_addr[3 +: IdxW];
  assign rd_line = mem_q[idx];

  // Next return: the entry one cycle from expiry, or a fresh load when LATENCY is 1.
  // Fixed latency with one accept per cycle guarantees at most one candidate.
  always_comb begin
    ret_tag_d  = 4'd0;
    ret_data_d = 64'h0;
    for (int t = 1; t <= 15; t++) begin
      if (busy_q[t] && cnt_q[t] == 4'd1) begin
        ret_tag_d  = 4'(t);
        ret_data_d = line_q[t];
      end
    end
    if (accept && is_load && CntInit == 4'd0) begin
      ret_tag_d  = free_tag;
      ret_data_d = rd_line;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(MEM_LINES); i++) mem_q[i] <= 64'h0;
    end else if (accept && is_store) begin
      mem_q[idx] <= dcache2ctlr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q         <= '0;
      Ctlr2proc_tag  <= 4'd0;
      Ctlr2proc_data <= 64'h0;
      for (int t = 1; t <= 15; t++) begin
        cnt_q[t]  <= 4'd0;
        line_q[t] <= 64'h0;
      end
    end else begin
      Ctlr2proc_tag  <= ret_tag_d;
      Ctlr2proc_data <= ret_data_d;
      for (int t = 1; t <= 15; t++) begin
        if (busy_q[t]) begin
          // Busy clears at the end of the return cycle.
          if (cnt_q[t] == 4'd0) busy_q[t] <= 1'b0;
          else                  cnt_q[t]  <= cnt_q[t] - 4'd1;
        end
      end
      // A granted tag is never busy, so this cannot collide with the updates above.
      if (accept && is_load) begin
        busy_q[free_tag] <= 1'b1;
        cnt_q[free_tag]  <= CntInit;
        line_q[free_tag] <= rd_line;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctlr.sv
`ifndef XLEN
`define XLEN 32
`endif

module tb_dmem_ctlr;

  localparam int unsigned LAT   = 14;
  localparam int unsigned LINES = 256;
  localparam int unsigned IW    = $clog2(LINES);

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       cmd   = 2'd0;
  logic [`XLEN-1:0] addr  = '0;
  logic [63:0]      wdata = 64'h0;
  logic [3:0]       resp;
  logic [3:0]       rtag;
  logic [63:0]      rdata;

  always #5 clock = ~clock;

  dmem_ctlr #(
    .LATENCY   (LAT),
    .MEM_LINES (LINES)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .dcache2ctlr_command (cmd),
    .dcache2ctlr_addr    (addr),
    .dcache2ctlr_data    (wdata),
    .Ctlr2proc_response  (resp),
    .Ctlr2proc_data      (rdata),
    .Ctlr2proc_tag       (rtag)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: line contents, and for each tag the first cycle it may be granted.
  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
  } ret_t;

  ret_t        sb [$];
  logic [63:0] mem_m [LINES];
  int          free_from [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(LINES); i++) mem_m[i] = 64'h0;
    for (int t = 0; t < 16; t++) free_from[t] = 0;
  endtask

  // Drive one cycle of stimulus; check the same-cycle grant and record expected returns.
  task automatic issue(input logic [1:0] c, input logic [`XLEN-1:0] a, input logic [63:0] d);
    logic [3:0]    exp_tag;
    logic [IW-1:0] li;
    cmd     = c;
    addr    = a;
    wdata   = d;
    exp_tag = 4'd0;
    if (c == 2'd1 || c == 2'd2) begin
      for (int t = 1; t <= 15; t++) begin
        if (free_from[t] <= cyc) begin
          exp_tag = 4'(t);
          break;
        end
      end
    end
    @(negedge clock);
    check("response", resp, exp_tag);
    li = a[3 +: IW];
    if (exp_tag != 0) begin
      if (c == 2'd2) begin
        mem_m[li] = d;
      end else begin
        sb.push_back('{due: cyc + int'(LAT), tag: exp_tag, data: mem_m[li]});
        free_from[exp_tag] = cyc + int'(LAT) + 1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(2'd0, '0, 64'h0);
  endtask

  // One reset cycle with a LOAD presented; in-flight loads not yet returning are dropped.
  task automatic do_reset();
    ret_t keep [$];
    reset = 1'b1;
    cmd   = 2'd1;
    addr  = 32'h40;
    foreach (sb[i]) if (sb[i].due <= cyc) keep.push_back(sb[i]);
    sb = keep;
    @(negedge clock);
    check("reset_response", resp, 4'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cmd   = 2'd0;
    model_clear();
  endtask

  // Monitor: returns must match the scoreboard head in tag, data and cycle.
  always @(negedge clock) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      check("ret_tag", rtag, sb[0].tag);
      check("ret_data", rdata, sb[0].data);
      void'(sb.pop_front());
    end else begin
      check("idle_tag", rtag, 4'd0);
      check("idle_data", rdata, 64'h0);
    end
  end

  initial begin
    logic [`XLEN-1:0] a;
    int               r;
    model_clear();
    @(posedge clock);
    #1;
    do_reset();

    // Load of a cleared line, then store-before-load and load-before-store ordering.
    issue(2'd1, 32'h40, 64'h0);
    issue(2'd2, 32'h48, 64'hDEAD_BEEF_0123_4567);
    issue(2'd1, 32'h48, 64'h0);
    issue(2'd1, 32'h80, 64'h0);
    issue(2'd2, 32'h80, 64'h1);
    issue(2'd1, 32'h80, 64'h0);
    idle(LAT + 2);

    // Back-to-back loads: every tag in use, tag 1 re-granted right after it returns.
    for (int i = 0; i < 18; i++) issue(2'd1, 32'(i * 8), 64'h0);
    idle(LAT + 2);

    // Reset while a load is in flight: no return, pool starts again from tag 1.
    issue(2'd1, 32'h48, 64'h0);
    idle(1);
    do_reset();
    idle(10);
    issue(2'd1, 32'h48, 64'h0);
    idle(2);

    // Random traffic over a few lines with aliasing upper address bits.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 199));
      if (r == 0) begin
        do_reset();
      end else begin
        a = $urandom & 32'hFFFF_F83F;
        issue(2'($urandom_range(0, 3)), a, {$urandom, $urandom});
      end
    end
    idle(LAT + 3);

    check("drain", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
